tape_line_conditioner: RTL and testbench
========================================

// Module: tape_line_conditioner
// PURPOSE
//  Conditions the raw line-level tape input (UART_RXD pin) before the console
//  tape input svi_tap_i. Synchronises, optionally inverts and glitch-filters
//  the pin with a hysteresis counter, then gates it with the cassette motor.
//  Also outputs a half-cycle period measurement and an activity flag for the
//  LED and future tape-counter/waveform logic. Sits between the tape pin and
//  the status[15] tape-source mux.
// PARAMETERS
//  FILT_LEN     8         ce ticks of stable level needed to flip filtered state (>=1)
//  PER_W        16        width of period counter/output, in bits
//  ACT_TIMEOUT  1048576   ce ticks activity stays high after the last filtered edge
// PORTS
//  clk         in   1      system clock (clk_sys)
//  reset       in   1      synchronous, active-high reset
//  ce          in   1      sample enable (ce_21m3 in top); all counters advance only on ce
//  tape_raw    in   1      asynchronous line input from pin
//  invert      in   1      1 = invert polarity after synchroniser
//  motor_on    in   1      1 = cassette motor running (~motor_o from console)
//  tape_out    out  1      filtered, motor-gated tape level to console
//  activity    out  1      high while filtered edges seen within ACT_TIMEOUT ticks
//  period      out  PER_W  ce ticks between the last two filtered edges
//  period_vld  out  1      one-clk strobe when period updates
// BEHAVIOUR
//  - Reset (synchronous): sync FFs, filter counter, filtered state, period counter,
//    activity timer, all outputs = 0; first-edge flag set.
//  - Synchroniser: 2 FFs on every clk (not ce-gated); s = sync2 ^ invert.
//  - Filter: counter fc in 0..FILT_LEN, on ce: s=1 -> fc+1 saturating at FILT_LEN;
//    s=0 -> fc-1 saturating at 0. Filtered state f <= 1 when fc reaches FILT_LEN,
//    f <= 0 when fc reaches 0, otherwise holds (hysteresis).
//  - Filtered edge e = one-clk pulse when f changes (either direction).
//  - tape_out registered: tape_out <= motor_on ? f : 0. With ce=1 every clk and
//    fc at the opposite rail, raw change -> tape_out change in 2+FILT_LEN+1 clks.
//  - Glitch shorter than FILT_LEN ticks never toggles f; spikes partially recharge fc.
//  - Period: per_cnt increments on ce, saturates at 2^PER_W-1. On e with motor_on=1:
//    if first-edge flag clear, period <= per_cnt and period_vld=1 for one clk;
//    per_cnt <= 0; first-edge flag cleared. e coinciding with a ce tick: the edge
//    wins (per_cnt <= 0, no increment). Saturated per_cnt is reported as all-ones.
//  - motor_on=0: per_cnt held 0, first-edge flag set, period holds last value,
//    period_vld=0. Filter and activity keep running.
//  - Activity: timer loaded with ACT_TIMEOUT on e, else decremented on ce down to 0;
//    activity <= (timer != 0), registered, independent of motor_on.
//  - Reset asserted mid-operation clears everything on the next clk regardless
//    of ce; outputs are 0 the clk after reset is sampled high.
//  - Width rules: fc is $clog2(FILT_LEN+1) bits; timer is $clog2(ACT_TIMEOUT+1) bits.
// TESTING
//  1 FILT_LEN=8, ce=1, motor_on=1, tape_raw 0->1 held -> tape_out rises exactly 11 clks later.
//  2 3-clk high pulse on tape_raw (fc starting 0) -> tape_out stays 0, period_vld never fires.
//  3 Square wave, 100 ce ticks per half-cycle, motor_on=1 -> first edge gives no strobe;
//    every later edge gives period=100 with a 1-clk period_vld.
//  4 motor_on=0 with toggling input -> tape_out=0, period_vld=0, activity=1;
//    raise motor_on -> first edge gives no strobe, second edge gives a valid period.
//  5 PER_W=4, half-cycle 40 ticks -> period=15 (saturated).
//  6 invert=1, raw held 0 -> tape_out=1 after latency; reset pulse mid-wave -> all outputs 0 next clk.

Source files
------------

// File: rtl/tape_line_conditioner.sv
// ---------------------------------------------------------------------------
// tape_line_conditioner
//
// Conditions the raw line-level cassette input pin before it reaches the
// console tape input. The pin is synchronised, optionally inverted, then
// glitch-filtered by a saturating up/down counter with hysteresis. The
// filtered level is gated by the cassette motor. The block also measures the
// half-cycle period between filtered edges and raises an activity flag while
// edges keep arriving.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   ce         in   1      sample enable; all counters advance only on ce
//   tape_raw   in   1      asynchronous line input from the pin
//   invert     in   1      1 = invert polarity after the synchroniser
//   motor_on   in   1      1 = cassette motor running
//   tape_out   out  1      filtered, motor-gated tape level
//   activity   out  1      high while filtered edges seen within ACT_TIMEOUT ticks
//   period     out  PER_W  ce ticks between the last two filtered edges
//   period_vld out  1      one-clk strobe when period updates
// ---------------------------------------------------------------------------
module tape_line_conditioner #(
    parameter int FILT_LEN    = 8,
    parameter int PER_W       = 16,
    parameter int ACT_TIMEOUT = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             tape_raw,
    input  logic             invert,
    input  logic             motor_on,
    output logic             tape_out,
    output logic             activity,
    output logic [PER_W-1:0] period,
    output logic             period_vld
);

    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam int TM_W = $clog2(ACT_TIMEOUT + 1);

    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_LEN);
    localparam logic [TM_W-1:0] TM_MAX = TM_W'(ACT_TIMEOUT);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;

    logic [FC_W-1:0]  r_fc;
    logic [FC_W-1:0]  w_fc_next;
    logic             r_f;
    logic             w_f_next;
    logic             w_edge;

    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W-1:0] w_per_ticks;
    logic             r_first;

    logic [TM_W-1:0]  r_timer;

    // Two-flop synchroniser runs on every clk, not gated by ce.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= tape_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ invert;

    // Hysteresis filter: the filtered state only flips when the counter hits
    // a rail; anywhere in between it holds, so short spikes just nudge fc.
    // The state is derived from the next counter value so f flips on the
    // same clk that fc reaches the rail.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fc_next = r_fc;
        w_f_next  = r_f;
        if (ce) begin
            if (w_s) begin
                if (r_fc != FC_MAX) w_fc_next = r_fc + 1'b1;
            end else begin
                if (r_fc != '0) w_fc_next = r_fc - 1'b1;
            end
        end
        if (w_fc_next == FC_MAX) begin
            w_f_next = 1'b1;
        end else if (w_fc_next == '0) begin
            w_f_next = 1'b0;
        end
    end

    assign w_edge = (w_f_next != r_f);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fc     <= '0;
            r_f      <= 1'b0;
            tape_out <= 1'b0;
        end else begin
            r_fc     <= w_fc_next;
            r_f      <= w_f_next;
            tape_out <= motor_on & r_f;
        end
    end

    // Tick count including the current ce tick, saturating at all-ones. On an
    // edge this is the number of ce ticks since the previous edge; the edge
    // itself restarts the counter at 0 rather than incrementing it.
    assign w_per_ticks = (ce && (r_per_cnt != '1)) ? r_per_cnt + 1'b1 : r_per_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_per_cnt  <= '0;
            r_first    <= 1'b1;
            period     <= '0;
            period_vld <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            if (!motor_on) begin
                // Motor stopped: the next edge after restart only re-arms.
                r_per_cnt <= '0;
                r_first   <= 1'b1;
            end else if (w_edge) begin
                if (!r_first) begin
                    period     <= w_per_ticks;
                    period_vld <= 1'b1;
                end
                r_per_cnt <= '0;
                r_first   <= 1'b0;
            end else begin
                r_per_cnt <= w_per_ticks;
            end
        end
    end

    // Activity timer runs regardless of the motor so the LED still shows a
    // signal on the line while the cassette is stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer  <= '0;
            activity <= 1'b0;
        end else begin
            activity <= (r_timer != '0);
            if (w_edge) begin
                r_timer <= TM_MAX;
            end else if (ce && (r_timer != '0)) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tape_line_conditioner.sv
module tb_tape_line_conditioner;

    localparam int FL      = 8;
    localparam int ACT_TO  = 300;
    localparam int MAX_A   = 65535;
    localparam int MAX_B   = 15;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        tape_raw;
    logic        invert;
    logic        motor_on;
    logic        tape_out_a, activity_a, period_vld_a;
    logic [15:0] period_a;
    logic        tape_out_b, activity_b, period_vld_b;
    logic [3:0]  period_b;

    int n_checks = 0;
    int n_err    = 0;

    tape_line_conditioner #(.FILT_LEN(FL), .PER_W(16), .ACT_TIMEOUT(ACT_TO)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .tape_raw(tape_raw), .invert(invert),
        .motor_on(motor_on), .tape_out(tape_out_a), .activity(activity_a),
        .period(period_a), .period_vld(period_vld_a)
    );

    tape_line_conditioner #(.FILT_LEN(FL), .PER_W(4), .ACT_TIMEOUT(ACT_TO)) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .tape_raw(tape_raw), .invert(invert),
        .motor_on(motor_on), .tape_out(tape_out_b), .activity(activity_b),
        .period(period_b), .period_vld(period_vld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: pin delayed two clocks, a level integrator with
    // rails at 0 and FL, elapsed-tick bookkeeping between filtered edges and
    // a countdown for activity.
    bit m_s1 = 0, m_s2 = 0, m_f = 0, m_first = 1;
    int m_fc = 0, m_since = 0, m_timer = 0;
    bit e_tape = 0, e_act = 0, e_vld = 0;
    int e_per_a = 0, e_per_b = 0;

    always @(posedge clk) begin
        bit s, new_f, edge_seen;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_f = 0; m_first = 1;
            m_fc = 0; m_since = 0; m_timer = 0;
            e_tape = 0; e_act = 0; e_vld = 0; e_per_a = 0; e_per_b = 0;
        end else begin
            s      = m_s2 ^ invert;
            m_s2   = m_s1;
            m_s1   = tape_raw;
            e_tape = motor_on && m_f;
            e_act  = (m_timer != 0);
            if (ce) m_fc = s ? ((m_fc < FL) ? m_fc + 1 : FL) : ((m_fc > 0) ? m_fc - 1 : 0);
            new_f = m_f;
            if (m_fc == FL) new_f = 1;
            else if (m_fc == 0) new_f = 0;
            edge_seen = (new_f != m_f);
            m_f = new_f;
            e_vld = 0;
            if (!motor_on) begin
                m_since = 0;
                m_first = 1;
            end else begin
                m_since += int'(ce);
                if (edge_seen) begin
                    if (!m_first) begin
                        e_vld   = 1;
                        e_per_a = (m_since > MAX_A) ? MAX_A : m_since;
                        e_per_b = (m_since > MAX_B) ? MAX_B : m_since;
                    end
                    m_since = 0;
                    m_first = 0;
                end
            end
            if (edge_seen) m_timer = ACT_TO;
            else if (ce && m_timer > 0) m_timer--;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        chk("tape_out", {31'b0, tape_out_a}, {31'b0, e_tape});
        chk("activity", {31'b0, activity_a}, {31'b0, e_act});
        chk("period_vld", {31'b0, period_vld_a}, {31'b0, e_vld});
        chk("period", {16'b0, period_a}, e_per_a);
        chk("period_vld_b", {31'b0, period_vld_b}, {31'b0, e_vld});
        chk("period_b", {28'b0, period_b}, e_per_b);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Square wave: first edge after motor start gives no strobe, all later
    // edges report the half-cycle length (saturated in the narrow instance).
    task automatic run_wave(input int half, input int n_half, input string tag);
        int nv = 0;
        for (int h = 0; h < n_half; h++) begin
            tape_raw = ~tape_raw;
            for (int k = 0; k < half; k++) begin
                tick();
                if (period_vld_a) begin
                    nv++;
                    chk({tag, "_period"}, {16'b0, period_a}, half);
                end
                if (period_vld_b) chk({tag, "_period_b"}, {28'b0, period_b}, (half > MAX_B) ? MAX_B : half);
            end
        end
        chk({tag, "_nvld"}, nv, n_half - 1);
    endtask

    initial begin
        int  n;
        bit  saw_tape, saw_vld;
        reset = 1; ce = 1; tape_raw = 0; invert = 0; motor_on = 1;
        run(3);
        chk("rst_tape", {31'b0, tape_out_a}, 0);
        chk("rst_period", {16'b0, period_a}, 0);
        reset = 0;
        run(20);

        // Latency of a clean rising edge.
        tape_raw = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!tape_out_a && n < 40);
        chk("latency", n, 11);
        run(10);
        tape_raw = 0;
        run(25);

        // A 3-clk spike never reaches the filtered state.
        saw_tape = 0; saw_vld = 0;
        tape_raw = 1;
        run(3);
        tape_raw = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_tape |= tape_out_a;
            saw_vld  |= period_vld_a;
        end
        chk("glitch_tape", {31'b0, saw_tape}, 0);
        chk("glitch_vld", {31'b0, saw_vld}, 0);

        // Restart motor to re-arm, then square waves of 100 and 40 ticks.
        motor_on = 0;
        run(2);
        motor_on = 1;
        run_wave(100, 5, "sq100");
        motor_on = 0;
        run(2);
        motor_on = 1;
        run_wave(40, 5, "sq40");

        // Motor off: line activity visible, nothing reaches the console.
        motor_on = 0;
        saw_tape = 0; saw_vld = 0;
        for (int h = 0; h < 4; h++) begin
            tape_raw = ~tape_raw;
            for (int k = 0; k < 30; k++) begin
                tick();
                saw_tape |= tape_out_a;
                saw_vld  |= period_vld_a;
            end
        end
        chk("motoroff_tape", {31'b0, saw_tape}, 0);
        chk("motoroff_vld", {31'b0, saw_vld}, 0);
        chk("motoroff_act", {31'b0, activity_a}, 1);
        motor_on = 1;
        run_wave(30, 3, "motoron");

        // Activity decays after ACT_TIMEOUT quiet ticks.
        run(350);
        chk("act_timeout", {31'b0, activity_a}, 0);

        // Randomised segments: random level, duration, ce, motor and invert.
        for (int seg = 0; seg < 200; seg++) begin
            int dur;
            tape_raw = 1'($urandom_range(0, 1));
            dur      = $urandom_range(1, 25);
            if ($urandom_range(0, 9) == 0) motor_on = ~motor_on;
            if ($urandom_range(0, 19) == 0) invert = ~invert;
            for (int k = 0; k < dur; k++) begin
                ce = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        ce = 1; motor_on = 1; invert = 0; tape_raw = 0;
        run(30);

        // Inverted polarity: pin held low reads as a high level.
        invert = 1;
        tape_raw = 0;
        run(15);
        chk("invert_tape", {31'b0, tape_out_a}, 1);

        // Reset mid-wave clears every output on the next clk.
        for (int h = 0; h < 3; h++) begin
            tape_raw = ~tape_raw;
            run(30);
        end
        tape_raw = ~tape_raw;
        run(5);
        reset = 1;
        tick();
        chk("midrst_tape", {31'b0, tape_out_a}, 0);
        chk("midrst_act", {31'b0, activity_a}, 0);
        chk("midrst_period", {16'b0, period_a}, 0);
        chk("midrst_vld", {31'b0, period_vld_a}, 0);
        reset = 0;
        run(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
